pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 11 +
 rtl/sync_2ff.sv | 14 +
 rtl/pll_lock_supervisor.sv | 116 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: supervisor state encodings and heartbeat window shared by the PLL lock supervisor
package pll_sup_pkg;
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;
    localparam int HB_WINDOW = 256;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with synchronous active-low reset
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    always_ff @(posedge clk) begin
        meta_q <= rst & d;
        sync_q <= rst & meta_q;
    end
    assign q = sync_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock sequencer; PLL_SUP_HEARTBEAT_EN adds hb_toggle liveness monitoring in RUN
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             retry,
`ifdef PLL_SUP_HEARTBEAT_EN
    input  logic             hb_toggle,
`endif
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] loss_cnt
);
    state_e state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, retry_cnt_q, retry_cnt_d, loss_cnt_q, loss_cnt_d;
    logic pll_rst_q, sys_rst_n_q, fault_q;
    logic locked_s, hb_edge, hb_lost;

    sync_2ff u_sync_locked (.clk(refclk), .rst(rst), .d(locked), .q(locked_s));

`ifdef PLL_SUP_HEARTBEAT_EN
    logic hb_s, hb_prev_q;
    sync_2ff u_sync_hb (.clk(refclk), .rst(rst), .d(hb_toggle), .q(hb_s));
    always_ff @(posedge refclk) hb_prev_q <= rst & hb_s;
    assign hb_edge = hb_s ^ hb_prev_q;
    assign hb_lost = !hb_edge && timer_q == CNT_W'(HB_WINDOW - 1);
`else
    // Holding hb_edge high keeps the RUN timer cleared when no heartbeat is monitored
    assign hb_edge = 1'b1;
    assign hb_lost = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + CNT_W'(1);
        retry_cnt_d = retry_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        unique case (state_q)
            RESET_PLL: if (timer_q == CNT_W'(RST_CYCLES - 1)) begin
                state_d = WAIT_LOCK;
                timer_d = '0;
            end
            WAIT_LOCK: if (locked_s) begin
                state_d = STABLE;
                timer_d = '0;
            end else if (timer_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                timer_d = '0;
                if (retry_cnt_q == CNT_W'(MAX_RETRIES - 1)) state_d = FAULT;
                else begin
                    state_d     = RESET_PLL;
                    retry_cnt_d = retry_cnt_q + CNT_W'(1);
                end
            end
            STABLE: if (!locked_s) begin
                state_d = WAIT_LOCK;
                timer_d = '0;
            end else if (timer_q == CNT_W'(STABLE_CYCLES - 1)) begin
                state_d     = RUN;
                timer_d     = '0;
                retry_cnt_d = '0;
            end
            RUN: if (!locked_s || hb_lost) begin
                state_d    = RESET_PLL;
                timer_d    = '0;
                loss_cnt_d = &loss_cnt_q ? loss_cnt_q : loss_cnt_q + CNT_W'(1);
            end else timer_d = hb_edge ? '0 : timer_q + CNT_W'(1);
            FAULT: begin
                timer_d = '0;
                if (retry) begin
                    state_d     = RESET_PLL;
                    retry_cnt_d = '0;
                end
            end
            default: begin
                state_d = RESET_PLL;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q     <= RESET_PLL;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_cnt_q <= retry_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_rst_q   <= state_d == RESET_PLL || state_d == FAULT;
            sys_rst_n_q <= state_d == RUN;
            fault_q     <= state_d == FAULT;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign fault     = fault_q;
    assign state_o   = state_q;
    assign loss_cnt  = loss_cnt_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed checks of reset, lock sequencing, retries, lock loss and fault recovery
module tb_pll_lock_supervisor;
    localparam int LT = 1000;
    logic refclk = 1'b0, rst = 1'b0, locked = 1'b0, retry = 1'b0, hb = 1'b0;
    logic pll_rst, sys_rst_n, fault;
    logic [2:0] state_o;
    logic [15:0] loss_cnt;
    int checks = 0, failures = 0;
    int hi, rises, first_fault, second_rise;
    logic prev;

    pll_lock_supervisor #(.LOCK_TIMEOUT(LT)) dut (
        .refclk(refclk),
        .rst(rst),
        .locked(locked),
        .retry(retry),
`ifdef PLL_SUP_HEARTBEAT_EN
        .hb_toggle(hb),
`endif
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .fault(fault),
        .state_o(state_o),
        .loss_cnt(loss_cnt)
    );

    always #5 refclk = ~refclk;
    always #20 hb = ~hb;

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic count_hi(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (pll_rst) cnt++;
            tick(1);
        end
    endtask

    initial begin
        tick(3);
        check("rst_state", state_o, 0);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_fault", fault, 0);
        check("rst_loss", loss_cnt, 0);
        rst = 1'b1;
        count_hi(40, hi);
        check("pulse_len", hi, 16);
        check("wait_lock", state_o, 1);
        locked = 1'b1;
        tick(1026);
        check("stable_before_run", state_o, 2);
        check("sysrst_before_run", sys_rst_n, 0);
        tick(1);
        check("run_entry", state_o, 3);
        check("run_sys_rst_n", sys_rst_n, 1);
        check("run_pll_rst", pll_rst, 0);
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        tick(1);
        check("retry_ignored", state_o, 3);
        locked = 1'b0;
        tick(2);
        check("loss_sysrst_hold", sys_rst_n, 1);
        tick(1);
        check("loss_sysrst_fall", sys_rst_n, 0);
        check("loss_state", state_o, 0);
        check("loss_cnt_inc", loss_cnt, 1);
        count_hi(30, hi);
        check("loss_pulse_len", hi, 16);
        locked = 1'b1;
        tick(502);
        check("stable_mid", state_o, 2);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        check("glitch_wait", state_o, 1);
        tick(1);
        check("glitch_restable", state_o, 2);
        tick(1023);
        check("glitch_no_early_run", state_o, 2);
        tick(1);
        check("glitch_run", state_o, 3);
        check("loss_kept", loss_cnt, 1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("abort_state", state_o, 0);
        check("abort_pll_rst", pll_rst, 1);
        check("abort_sys_rst_n", sys_rst_n, 0);
        check("abort_fault", fault, 0);
        check("abort_loss", loss_cnt, 0);
        count_hi(20, hi);
        check("abort_pulse_len", hi, 16);
        locked = 1'b0;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        hi = 0;
        rises = 0;
        first_fault = -1;
        second_rise = -1;
        prev = 1'b0;
        for (int i = 0; i < 3100; i++) begin
            if (fault && first_fault < 0) first_fault = i;
            if (!fault && pll_rst) hi++;
            if (!fault && pll_rst && !prev) begin
                rises++;
                if (rises == 2) second_rise = i;
            end
            prev = pll_rst;
            tick(1);
        end
        check("retry_pulses", rises, 3);
        check("retry_hi_cycles", hi, 48);
        check("retry_spacing", second_rise, 16 + LT);
        check("fault_time", first_fault, 3 * (16 + LT));
        check("fault_flag", fault, 1);
        check("fault_pll_rst", pll_rst, 1);
        check("fault_state", state_o, 4);
        locked = 1'b1;
        tick(5);
        check("fault_holds", state_o, 4);
        retry = 1'b1;
        tick(1);
        retry = 1'b0;
        check("retry_exit_state", state_o, 0);
        check("retry_exit_fault", fault, 0);
        check("retry_exit_pll_rst", pll_rst, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
